reservation_station: RTL and testbench

- Holds dispatched ALU-class RV32I instructions (R, I, B, JAL, JALR, LUI, AUIPC) until both source operands are available.
- Snoops the two result broadcast buses (ALU and LSB) to wake waiting operands.
- Issues one ready instruction per cycle to the ALU: opcode, op word, vj, vk, pc, imm, plus the ROB tag.
- Sits between the dispatcher/decoder and the ALU in the Tomasulo core. It is the producer end of the ALU issue interface.

---
 rtl/reservation_station.sv | 173 +++++++++++++++++
 tb/tb_reservation_station.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reservation_station.sv
// Reservation station for ALU-class RV32I ops: holds entries until both operands
// are known, snoops the ALU/LSB broadcast buses, and issues one ready entry per cycle.
module reservation_station #(
    parameter int RS_SIZE   = 8,
    parameter int ROB_TAG_W = 4
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 clear_in,
    input  logic                 disp_valid,
    input  logic [6:0]           disp_opcode,
    input  logic [31:0]          disp_op,
    input  logic                 disp_qj_busy,
    input  logic [ROB_TAG_W-1:0] disp_qj,
    input  logic [31:0]          disp_vj,
    input  logic                 disp_qk_busy,
    input  logic [ROB_TAG_W-1:0] disp_qk,
    input  logic [31:0]          disp_vk,
    input  logic [31:0]          disp_pc,
    input  logic [31:0]          disp_imm,
    input  logic [ROB_TAG_W-1:0] disp_rob_tag,
    output logic                 rs_full,
    input  logic                 alu_cdb_valid,
    input  logic [ROB_TAG_W-1:0] alu_cdb_tag,
    input  logic [31:0]          alu_cdb_value,
    input  logic                 lsb_cdb_valid,
    input  logic [ROB_TAG_W-1:0] lsb_cdb_tag,
    input  logic [31:0]          lsb_cdb_value,
    output logic                 alu_valid,
    output logic [6:0]           alu_opcode,
    output logic [31:0]          alu_op,
    output logic [31:0]          alu_vj,
    output logic [31:0]          alu_vk,
    output logic [31:0]          alu_pc,
    output logic [31:0]          alu_imm,
    output logic [ROB_TAG_W-1:0] alu_rob_tag
);
    localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

    logic [RS_SIZE-1:0]   busy, qj_busy, qk_busy, ready, busy_nxt;
    logic [6:0]           e_opcode [RS_SIZE];
    logic [31:0]          e_op     [RS_SIZE];
    logic [31:0]          e_vj     [RS_SIZE];
    logic [31:0]          e_vk     [RS_SIZE];
    logic [31:0]          e_pc     [RS_SIZE];
    logic [31:0]          e_imm    [RS_SIZE];
    logic [ROB_TAG_W-1:0] e_qj     [RS_SIZE];
    logic [ROB_TAG_W-1:0] e_qk     [RS_SIZE];
    logic [ROB_TAG_W-1:0] e_tag    [RS_SIZE];

    logic [RS_SIZE-1:0] wj_hit, wk_hit;
    logic [31:0]        wj_val [RS_SIZE];
    logic [31:0]        wk_val [RS_SIZE];
    logic               dj_hit, dk_hit;
    logic [31:0]        dj_val, dk_val;
    logic [IDX_W-1:0]   sel_idx, free_idx;
    logic               any_ready, do_disp;

    assign ready   = busy & ~qj_busy & ~qk_busy;
    assign do_disp = disp_valid & ~rs_full;

    // Lowest index wins for both select and free-slot search.
    always_comb begin
        sel_idx   = '0;
        free_idx  = '0;
        any_ready = 1'b0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (ready[i]) begin
                sel_idx   = IDX_W'(i);
                any_ready = 1'b1;
            end
            if (!busy[i])
                free_idx = IDX_W'(i);
        end
        busy_nxt = busy;
        if (any_ready)
            busy_nxt[sel_idx] = 1'b0;
        if (do_disp)
            busy_nxt[free_idx] = 1'b1;
    end

    // Broadcast snoop; ALU takes precedence if both buses carry the same tag.
    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            wj_hit[i] = busy[i] & qj_busy[i] &
                        ((alu_cdb_valid & (alu_cdb_tag == e_qj[i])) |
                         (lsb_cdb_valid & (lsb_cdb_tag == e_qj[i])));
            wk_hit[i] = busy[i] & qk_busy[i] &
                        ((alu_cdb_valid & (alu_cdb_tag == e_qk[i])) |
                         (lsb_cdb_valid & (lsb_cdb_tag == e_qk[i])));
            wj_val[i] = (alu_cdb_valid && alu_cdb_tag == e_qj[i]) ? alu_cdb_value : lsb_cdb_value;
            wk_val[i] = (alu_cdb_valid && alu_cdb_tag == e_qk[i]) ? alu_cdb_value : lsb_cdb_value;
        end
        dj_hit = disp_qj_busy & ((alu_cdb_valid & (alu_cdb_tag == disp_qj)) |
                                 (lsb_cdb_valid & (lsb_cdb_tag == disp_qj)));
        dk_hit = disp_qk_busy & ((alu_cdb_valid & (alu_cdb_tag == disp_qk)) |
                                 (lsb_cdb_valid & (lsb_cdb_tag == disp_qk)));
        dj_val = !disp_qj_busy ? disp_vj :
                 (alu_cdb_valid && alu_cdb_tag == disp_qj) ? alu_cdb_value : lsb_cdb_value;
        dk_val = !disp_qk_busy ? disp_vk :
                 (alu_cdb_valid && alu_cdb_tag == disp_qk) ? alu_cdb_value : lsb_cdb_value;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            busy        <= '0;
            qj_busy     <= '0;
            qk_busy     <= '0;
            rs_full     <= 1'b0;
            alu_valid   <= 1'b0;
            alu_opcode  <= '0;
            alu_op      <= '0;
            alu_vj      <= '0;
            alu_vk      <= '0;
            alu_pc      <= '0;
            alu_imm     <= '0;
            alu_rob_tag <= '0;
        end else if (!rdy_in) begin
            alu_valid <= 1'b0;
        end else if (clear_in) begin
            busy      <= '0;
            rs_full   <= 1'b0;
            alu_valid <= 1'b0;
        end else begin
            busy      <= busy_nxt;
            rs_full   <= &busy_nxt;
            alu_valid <= any_ready;
            if (any_ready) begin
                alu_opcode  <= e_opcode[sel_idx];
                alu_op      <= e_op[sel_idx];
                alu_vj      <= e_vj[sel_idx];
                alu_vk      <= e_vk[sel_idx];
                alu_pc      <= e_pc[sel_idx];
                alu_imm     <= e_imm[sel_idx];
                alu_rob_tag <= e_tag[sel_idx];
            end
            for (int i = 0; i < RS_SIZE; i++) begin
                if (wj_hit[i])
                    qj_busy[i] <= 1'b0;
                if (wk_hit[i])
                    qk_busy[i] <= 1'b0;
            end
            if (do_disp) begin
                qj_busy[free_idx] <= disp_qj_busy & ~dj_hit;
                qk_busy[free_idx] <= disp_qk_busy & ~dk_hit;
            end
        end
    end

    // Payload carries no reset: it is only meaningful while the busy bit is set.
    always_ff @(posedge clk_in) begin
        if (rdy_in && !clear_in) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (wj_hit[i])
                    e_vj[i] <= wj_val[i];
                if (wk_hit[i])
                    e_vk[i] <= wk_val[i];
            end
            if (do_disp) begin
                e_opcode[free_idx] <= disp_opcode;
                e_op[free_idx]     <= disp_op;
                e_qj[free_idx]     <= disp_qj;
                e_qk[free_idx]     <= disp_qk;
                e_vj[free_idx]     <= dj_val;
                e_vk[free_idx]     <= dk_val;
                e_pc[free_idx]     <= disp_pc;
                e_imm[free_idx]    <= disp_imm;
                e_tag[free_idx]    <= disp_rob_tag;
            end
        end
    end
endmodule

// File: tb/tb_reservation_station.sv
// Scoreboard bench for reservation_station: a per-cycle behavioural model predicts
// every issue, and an independent monitor compares the ALU issue port against it.
module tb_reservation_station;
    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, clear_in;
    logic        disp_valid, disp_qj_busy, disp_qk_busy;
    logic [6:0]  disp_opcode;
    logic [31:0] disp_op, disp_vj, disp_vk, disp_pc, disp_imm;
    logic [3:0]  disp_qj, disp_qk, disp_rob_tag;
    logic        rs_full;
    logic        alu_cdb_valid, lsb_cdb_valid;
    logic [3:0]  alu_cdb_tag, lsb_cdb_tag;
    logic [31:0] alu_cdb_value, lsb_cdb_value;
    logic        alu_valid;
    logic [6:0]  alu_opcode;
    logic [31:0] alu_op, alu_vj, alu_vk, alu_pc, alu_imm;
    logic [3:0]  alu_rob_tag;

    int checks = 0;
    int failures = 0;

    reservation_station #(.RS_SIZE(8), .ROB_TAG_W(4)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
        .disp_valid(disp_valid), .disp_opcode(disp_opcode), .disp_op(disp_op),
        .disp_qj_busy(disp_qj_busy), .disp_qj(disp_qj), .disp_vj(disp_vj),
        .disp_qk_busy(disp_qk_busy), .disp_qk(disp_qk), .disp_vk(disp_vk),
        .disp_pc(disp_pc), .disp_imm(disp_imm), .disp_rob_tag(disp_rob_tag),
        .rs_full(rs_full),
        .alu_cdb_valid(alu_cdb_valid), .alu_cdb_tag(alu_cdb_tag), .alu_cdb_value(alu_cdb_value),
        .lsb_cdb_valid(lsb_cdb_valid), .lsb_cdb_tag(lsb_cdb_tag), .lsb_cdb_value(lsb_cdb_value),
        .alu_valid(alu_valid), .alu_opcode(alu_opcode), .alu_op(alu_op),
        .alu_vj(alu_vj), .alu_vk(alu_vk), .alu_pc(alu_pc), .alu_imm(alu_imm),
        .alu_rob_tag(alu_rob_tag)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic        busy;
        logic [6:0]  opcode;
        logic [31:0] op;
        logic        qjb;
        logic [3:0]  qj;
        logic [31:0] vj;
        logic        qkb;
        logic [3:0]  qk;
        logic [31:0] vk;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [3:0]  tag;
    } ent_t;

    typedef struct {
        logic [6:0]  opcode;
        logic [31:0] op, vj, vk, pc, imm;
        logic [3:0]  tag;
    } iss_t;

    ent_t m [8];
    logic m_full = 1'b0;
    iss_t exp_q [$];

    // {hit, value} for a tag looked up on this cycle's broadcast buses.
    function automatic logic [32:0] snoop(input logic [3:0] t);
        if (alu_cdb_valid && alu_cdb_tag == t) return {1'b1, alu_cdb_value};
        if (lsb_cdb_valid && lsb_cdb_tag == t) return {1'b1, lsb_cdb_value};
        return 33'd0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m[i].busy = 1'b0;
        m_full = 1'b0;
        exp_q.delete();
    endtask

    // Predicts the effect of the coming rising edge from the current inputs.
    task automatic model_step();
        int free_i, sel_i;
        logic [32:0] s;
        ent_t e;
        iss_t x;
        if (!rdy_in) return;
        if (clear_in) begin
            for (int i = 0; i < 8; i++) m[i].busy = 1'b0;
            m_full = 1'b0;
            return;
        end
        free_i = -1;
        sel_i = -1;
        for (int i = 0; i < 8; i++) begin
            if (!m[i].busy && free_i < 0) free_i = i;
            if (m[i].busy && !m[i].qjb && !m[i].qkb && sel_i < 0) sel_i = i;
        end
        if (sel_i >= 0) begin
            x.opcode = m[sel_i].opcode; x.op = m[sel_i].op; x.vj = m[sel_i].vj;
            x.vk = m[sel_i].vk; x.pc = m[sel_i].pc; x.imm = m[sel_i].imm; x.tag = m[sel_i].tag;
            exp_q.push_back(x);
            m[sel_i].busy = 1'b0;
        end
        for (int i = 0; i < 8; i++) begin
            if (m[i].busy && m[i].qjb) begin
                s = snoop(m[i].qj);
                if (s[32]) begin m[i].qjb = 1'b0; m[i].vj = s[31:0]; end
            end
            if (m[i].busy && m[i].qkb) begin
                s = snoop(m[i].qk);
                if (s[32]) begin m[i].qkb = 1'b0; m[i].vk = s[31:0]; end
            end
        end
        if (disp_valid && !m_full && free_i >= 0) begin
            e.busy = 1'b1; e.opcode = disp_opcode; e.op = disp_op; e.pc = disp_pc;
            e.imm = disp_imm; e.tag = disp_rob_tag; e.qj = disp_qj; e.qk = disp_qk;
            e.qjb = disp_qj_busy; e.vj = disp_vj; e.qkb = disp_qk_busy; e.vk = disp_vk;
            if (e.qjb) begin s = snoop(e.qj); if (s[32]) begin e.qjb = 1'b0; e.vj = s[31:0]; end end
            if (e.qkb) begin s = snoop(e.qk); if (s[32]) begin e.qkb = 1'b0; e.vk = s[31:0]; end end
            m[free_i] = e;
        end
        m_full = 1'b1;
        for (int i = 0; i < 8; i++) if (!m[i].busy) m_full = 1'b0;
    endtask

    // Monitor: looks just after each rising edge, independent of the driver.
    always @(posedge clk_in) begin
        iss_t x;
        #1;
        if (rst_in) begin
            if (alu_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_issue: got tag=%0d vj=%h with nothing expected", alu_rob_tag, alu_vj);
                end else begin
                    x = exp_q.pop_front();
                    if (alu_opcode !== x.opcode || alu_op !== x.op || alu_vj !== x.vj ||
                        alu_vk !== x.vk || alu_pc !== x.pc || alu_imm !== x.imm || alu_rob_tag !== x.tag) begin
                        failures++;
                        $display("FAIL issue_fields: got opc=%h op=%h vj=%h vk=%h pc=%h imm=%h tag=%0d want opc=%h op=%h vj=%h vk=%h pc=%h imm=%h tag=%0d",
                                 alu_opcode, alu_op, alu_vj, alu_vk, alu_pc, alu_imm, alu_rob_tag,
                                 x.opcode, x.op, x.vj, x.vk, x.pc, x.imm, x.tag);
                    end
                end
            end else if (exp_q.size() != 0) begin
                checks++;
                failures++;
                x = exp_q.pop_front();
                $display("FAIL missing_issue: got alu_valid=0 want issue of tag=%0d vj=%h", x.tag, x.vj);
            end
        end
    end

    task automatic idle();
        rdy_in = 1'b1; clear_in = 1'b0; disp_valid = 1'b0;
        alu_cdb_valid = 1'b0; lsb_cdb_valid = 1'b0;
    endtask

    task automatic set_disp(input logic [6:0] opc, input logic qjb, input logic [3:0] qj,
                            input logic [31:0] vj, input logic qkb, input logic [3:0] qk,
                            input logic [31:0] vk, input logic [31:0] imm, input logic [3:0] tag);
        disp_valid = 1'b1; disp_opcode = opc; disp_op = $urandom; disp_pc = $urandom;
        disp_qj_busy = qjb; disp_qj = qj; disp_vj = vj;
        disp_qk_busy = qkb; disp_qk = qk; disp_vk = vk;
        disp_imm = imm; disp_rob_tag = tag;
    endtask

    task automatic tick();
        model_step();
        @(negedge clk_in);
        checks++;
        if (rs_full !== m_full) begin
            failures++;
            $display("FAIL rs_full: got %b want %b", rs_full, m_full);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    localparam logic [6:0] OP_ADDI = 7'b0010011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_B    = 7'b1100011;

    initial begin
        logic [6:0] opcs [3];
        opcs[0] = OP_ADDI; opcs[1] = OP_R; opcs[2] = OP_B;
        rst_in = 1'b0;
        idle();
        set_disp(OP_R, 0, 0, 0, 0, 0, 0, 0, 0);
        disp_valid = 1'b0;
        alu_cdb_tag = '0; alu_cdb_value = '0; lsb_cdb_tag = '0; lsb_cdb_value = '0;
        model_reset();
        repeat (3) @(negedge clk_in);
        chk("reset_alu_valid", 32'(alu_valid), 0);
        chk("reset_rs_full", 32'(rs_full), 0);
        chk("reset_alu_vj", alu_vj, 0);
        chk("reset_alu_tag", 32'(alu_rob_tag), 0);
        rst_in = 1'b1;

        // ADDI with both operands ready: issues on the next edge, then idle.
        set_disp(OP_ADDI, 0, 0, 32'd5, 0, 0, 0, 32'd7, 4'd3);
        tick();
        idle(); tick(); tick();

        // ADD waiting on rs1 (tag 2), woken by the ALU bus three cycles later.
        set_disp(OP_R, 1, 4'd2, 32'hdead, 0, 0, 32'd10, 0, 4'd4);
        tick();
        idle(); tick(); tick();
        alu_cdb_valid = 1'b1; alu_cdb_tag = 4'd2; alu_cdb_value = 32'h20;
        tick();
        idle(); tick(); tick();

        // BEQ whose rs2 producer broadcasts on the LSB bus in the dispatch cycle.
        set_disp(OP_B, 0, 0, 32'd1, 1, 4'd6, 0, 32'h10, 4'd5);
        lsb_cdb_valid = 1'b1; lsb_cdb_tag = 4'd6; lsb_cdb_value = 32'hFFFFFFFF;
        tick();
        idle(); tick(); tick();

        // Fill all entries, try a ninth dispatch, then wake exactly one.
        for (int i = 0; i < 8; i++) begin
            set_disp(OP_R, 1, 4'(8 + i), 0, 0, 0, 32'(i), 0, 4'(i));
            tick();
        end
        set_disp(OP_ADDI, 0, 0, 32'd99, 0, 0, 0, 0, 4'd15);
        tick();
        idle();
        alu_cdb_valid = 1'b1; alu_cdb_tag = 4'd8; alu_cdb_value = 32'h1234;
        tick();
        idle(); tick(); tick();
        clear_in = 1'b1; tick(); idle(); tick();

        // Entries 1 and 4 become ready together; lower index goes first.
        for (int i = 0; i < 5; i++) begin
            set_disp(OP_R, 1, 4'(8 + i), 0, 0, 0, 32'(i + 100), 0, 4'(i));
            tick();
        end
        idle();
        alu_cdb_valid = 1'b1; alu_cdb_tag = 4'd9;  alu_cdb_value = 32'haaaa;
        lsb_cdb_valid = 1'b1; lsb_cdb_tag = 4'd12; lsb_cdb_value = 32'hbbbb;
        tick();
        idle(); tick(); tick(); tick();
        clear_in = 1'b1; tick(); idle();

        // Clear together with a dispatch drops everything, including the new op.
        for (int i = 0; i < 5; i++) begin
            set_disp(OP_R, 1, 4'd14, 0, 1, 4'd14, 0, 0, 4'(i));
            tick();
        end
        set_disp(OP_ADDI, 0, 0, 32'd77, 0, 0, 0, 32'd1, 4'd9);
        clear_in = 1'b1;
        tick();
        idle(); tick(); tick();

        // Stall for two cycles mid-stream with live-looking inputs.
        set_disp(OP_ADDI, 0, 0, 32'd1, 0, 0, 0, 32'd2, 4'd1); tick();
        set_disp(OP_ADDI, 1, 4'd3, 32'd0, 0, 0, 0, 32'd3, 4'd2); tick();
        set_disp(OP_R, 0, 0, 32'd4, 0, 0, 32'd5, 0, 4'd6);
        rdy_in = 1'b0;
        alu_cdb_valid = 1'b1; alu_cdb_tag = 4'd3; alu_cdb_value = 32'h55;
        tick(); tick();
        idle(); tick();
        alu_cdb_valid = 1'b1; alu_cdb_tag = 4'd3; alu_cdb_value = 32'h66;
        tick();
        idle(); tick(); tick();

        // Randomized traffic.
        for (int c = 0; c < 800; c++) begin
            idle();
            if ($urandom_range(0, 9) < 6)
                set_disp(opcs[$urandom_range(0, 2)], 1'($urandom_range(0, 9) < 4), 4'($urandom),
                         $urandom, 1'($urandom_range(0, 9) < 4), 4'($urandom), $urandom,
                         $urandom, 4'($urandom));
            alu_cdb_valid = 1'($urandom_range(0, 9) < 3);
            alu_cdb_tag = 4'($urandom); alu_cdb_value = $urandom;
            lsb_cdb_valid = 1'($urandom_range(0, 9) < 3);
            lsb_cdb_tag = 4'($urandom); lsb_cdb_value = $urandom;
            rdy_in = 1'($urandom_range(0, 9) != 0);
            clear_in = 1'($urandom_range(0, 99) < 2);
            tick();
        end

        // Asynchronous reset between edges empties the station immediately.
        idle();
        for (int i = 0; i < 6; i++) begin
            set_disp(OP_R, 1, 4'd15, 0, 0, 0, 0, 0, 4'(i));
            tick();
        end
        idle();
        #2 rst_in = 1'b0;
        #1;
        chk("async_rst_alu_valid", 32'(alu_valid), 0);
        chk("async_rst_rs_full", 32'(rs_full), 0);
        chk("async_rst_alu_imm", alu_imm, 0);
        model_reset();
        @(negedge clk_in);
        rst_in = 1'b1;
        set_disp(OP_ADDI, 0, 0, 32'd42, 0, 0, 0, 32'd8, 4'd11);
        tick();
        idle(); tick(); tick();

        chk("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
